// File: rtl/sys_ctrl_pkg.sv
// Shared types and constants for the command sequencer between UART RX/TX, register file and ALU.
package SYS_PKG;
  localparam int FRAME_W = 8;

  typedef logic [FRAME_W-1:0] dataframe_t;

  localparam dataframe_t CMD_WR      = 8'hAA;
  localparam dataframe_t CMD_RD      = 8'hBB;
  localparam dataframe_t CMD_ALU_OP  = 8'hCC;
  localparam dataframe_t CMD_ALU_NOP = 8'hDD;

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, RESP
  } main_state_t;

  typedef enum logic [1:0] {
    T_IDLE, T_LOAD, T_WAIT_HI, T_WAIT_LO
  } tx_state_t;
endpackage

// File: rtl/sys_ctrl_tx_seq.sv
// Response buffer (up to two bytes, low byte first) streamed into UART_TX under its Busy handshake.
module sys_ctrl_tx_seq
  import SYS_PKG::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic [1:0]            len,
  input  logic [DATA_WIDTH-1:0] byte0,
  input  logic [DATA_WIDTH-1:0] byte1,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_data_valid,
  input  logic                  tx_busy
);

  tx_state_t state, state_nxt;
  logic [DATA_WIDTH-1:0] rsp0, rsp1, rsp0_nxt, rsp1_nxt, tx_data_nxt;
  logic two, two_nxt, idx, idx_nxt, tx_data_valid_nxt, more;

  assign more = two && !idx;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= T_IDLE;
      rsp0          <= '0;
      rsp1          <= '0;
      two           <= 1'b0;
      idx           <= 1'b0;
      tx_data       <= '0;
      tx_data_valid <= 1'b0;
    end else begin
      state         <= state_nxt;
      rsp0          <= rsp0_nxt;
      rsp1          <= rsp1_nxt;
      two           <= two_nxt;
      idx           <= idx_nxt;
      tx_data       <= tx_data_nxt;
      tx_data_valid <= tx_data_valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      T_IDLE:    if (load) state_nxt = T_LOAD;
      T_LOAD:    if (!tx_busy) state_nxt = T_WAIT_HI;
      T_WAIT_HI: if (tx_busy) state_nxt = T_WAIT_LO;
      T_WAIT_LO: if (!tx_busy) state_nxt = more ? T_WAIT_HI : T_IDLE;
      default:   state_nxt = T_IDLE;
    endcase
  end

  // The second byte is loaded straight from T_WAIT_LO so it follows the Busy fall by one cycle.
  always_comb begin
    rsp0_nxt          = rsp0;
    rsp1_nxt          = rsp1;
    two_nxt           = two;
    idx_nxt           = idx;
    tx_data_nxt       = tx_data;
    tx_data_valid_nxt = 1'b0;
    done              = 1'b0;
    unique case (state)
      T_IDLE: begin
        if (load) begin
          rsp0_nxt = byte0;
          rsp1_nxt = byte1;
          two_nxt  = (len == 2'd2);
          idx_nxt  = 1'b0;
        end
      end
      T_LOAD: begin
        if (!tx_busy) begin
          tx_data_valid_nxt = 1'b1;
          tx_data_nxt       = rsp0;
        end
      end
      T_WAIT_LO: begin
        if (!tx_busy) begin
          if (more) begin
            tx_data_valid_nxt = 1'b1;
            tx_data_nxt       = rsp1;
            idx_nxt           = 1'b1;
          end else begin
            done = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sys_ctrl.sv
// Command sequencer: parses RX frames, drives register-file / ALU strobes, returns responses via UART_TX.
//   state    | meaning
//   IDLE     | waiting for an opcode frame
//   WR_ADDR  | write: waiting for address frame
//   WR_DATA  | write: waiting for data frame
//   RD_ADDR  | read: waiting for address frame
//   RD_WAIT  | read: waiting for rf_rd_valid
//   OP_A     | ALU: waiting for operand A (written to address 0)
//   OP_B     | ALU: waiting for operand B (written to address 1)
//   ALU_FUN  | ALU: waiting for function frame
//   ALU_WAIT | ALU: waiting for alu_out_valid
//   RESP     | response streaming through the TX sequencer
module sys_ctrl
  import SYS_PKG::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int ALU_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_data_valid,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic                  rf_wr_en,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  rf_rd_en,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  input  logic                  rf_rd_valid,
  output logic [3:0]            alu_fun,
  output logic                  alu_en,
  input  logic [ALU_WIDTH-1:0]  alu_out,
  input  logic                  alu_out_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_data_valid,
  input  logic                  tx_busy,
  output logic                  cmd_error,
  output logic                  overrun
);

  main_state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] rf_addr_nxt;
  logic [DATA_WIDTH-1:0] rf_wr_data_nxt;
  logic [3:0] alu_fun_nxt;
  logic rf_wr_en_nxt, rf_rd_en_nxt, alu_en_nxt, cmd_error_nxt, overrun_nxt;
  logic tx_load, tx_done;
  logic [1:0] tx_len;
  logic [DATA_WIDTH-1:0] tx_byte0, tx_byte1;
  logic op_wr, op_rd, op_alu, op_nop;

  assign op_wr  = (rx_data == DATA_WIDTH'(CMD_WR));
  assign op_rd  = (rx_data == DATA_WIDTH'(CMD_RD));
  assign op_alu = (rx_data == DATA_WIDTH'(CMD_ALU_OP));
  assign op_nop = (rx_data == DATA_WIDTH'(CMD_ALU_NOP));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      rf_addr    <= '0;
      rf_wr_en   <= 1'b0;
      rf_wr_data <= '0;
      rf_rd_en   <= 1'b0;
      alu_fun    <= '0;
      alu_en     <= 1'b0;
      cmd_error  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      rf_addr    <= rf_addr_nxt;
      rf_wr_en   <= rf_wr_en_nxt;
      rf_wr_data <= rf_wr_data_nxt;
      rf_rd_en   <= rf_rd_en_nxt;
      alu_fun    <= alu_fun_nxt;
      alu_en     <= alu_en_nxt;
      cmd_error  <= cmd_error_nxt;
      overrun    <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (rx_data_valid) begin
          if (op_wr)       state_nxt = WR_ADDR;
          else if (op_rd)  state_nxt = RD_ADDR;
          else if (op_alu) state_nxt = OP_A;
          else if (op_nop) state_nxt = ALU_FUN;
        end
      end
      WR_ADDR:  if (rx_data_valid) state_nxt = WR_DATA;
      WR_DATA:  if (rx_data_valid) state_nxt = IDLE;
      RD_ADDR:  if (rx_data_valid) state_nxt = RD_WAIT;
      RD_WAIT:  if (rf_rd_valid) state_nxt = RESP;
      OP_A:     if (rx_data_valid) state_nxt = OP_B;
      OP_B:     if (rx_data_valid) state_nxt = ALU_FUN;
      ALU_FUN:  if (rx_data_valid) state_nxt = ALU_WAIT;
      ALU_WAIT: if (alu_out_valid) state_nxt = RESP;
      RESP:     if (tx_done) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rf_addr_nxt    = rf_addr;
    rf_wr_data_nxt = rf_wr_data;
    alu_fun_nxt    = alu_fun;
    rf_wr_en_nxt   = 1'b0;
    rf_rd_en_nxt   = 1'b0;
    alu_en_nxt     = 1'b0;
    cmd_error_nxt  = 1'b0;
    overrun_nxt    = 1'b0;
    tx_load        = 1'b0;
    tx_len         = 2'd1;
    tx_byte0       = '0;
    tx_byte1       = '0;
    unique case (state)
      IDLE: cmd_error_nxt = rx_data_valid && !(op_wr || op_rd || op_alu || op_nop);
      WR_ADDR: if (rx_data_valid) rf_addr_nxt = rx_data[ADDR_WIDTH-1:0];
      WR_DATA: begin
        if (rx_data_valid) begin
          rf_wr_en_nxt   = 1'b1;
          rf_wr_data_nxt = rx_data;
        end
      end
      RD_ADDR: begin
        if (rx_data_valid) begin
          rf_addr_nxt  = rx_data[ADDR_WIDTH-1:0];
          rf_rd_en_nxt = 1'b1;
        end
      end
      RD_WAIT: begin
        overrun_nxt = rx_data_valid;
        tx_load     = rf_rd_valid;
        tx_byte0    = rf_rd_data;
      end
      OP_A, OP_B: begin
        if (rx_data_valid) begin
          rf_addr_nxt    = (state == OP_A) ? ADDR_WIDTH'(0) : ADDR_WIDTH'(1);
          rf_wr_en_nxt   = 1'b1;
          rf_wr_data_nxt = rx_data;
        end
      end
      ALU_FUN: begin
        if (rx_data_valid) begin
          alu_en_nxt  = 1'b1;
          alu_fun_nxt = rx_data[3:0];
        end
      end
      ALU_WAIT: begin
        overrun_nxt = rx_data_valid;
        tx_load     = alu_out_valid;
        tx_len      = 2'd2;
        tx_byte0    = alu_out[DATA_WIDTH-1:0];
        tx_byte1    = alu_out[ALU_WIDTH-1 -: DATA_WIDTH];
      end
      RESP: overrun_nxt = rx_data_valid;
      default: ;
    endcase
  end

  sys_ctrl_tx_seq #(.DATA_WIDTH(DATA_WIDTH)) u_tx_seq (
    .CLK           (CLK),
    .RST           (RST),
    .load          (tx_load),
    .len           (tx_len),
    .byte0         (tx_byte0),
    .byte1         (tx_byte1),
    .done          (tx_done),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_busy       (tx_busy)
  );

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed bench for sys_ctrl with register-file, ALU and UART_TX behavioural models and a response scoreboard.
module tb_sys_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_data_valid = 1'b0;
  logic [3:0]  rf_addr;
  logic        rf_wr_en;
  logic [7:0]  rf_wr_data;
  logic        rf_rd_en;
  logic [7:0]  rf_rd_data = '0;
  logic        rf_rd_valid = 1'b0;
  logic [3:0]  alu_fun;
  logic        alu_en;
  logic [15:0] alu_out = '0;
  logic        alu_out_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_busy = 1'b0;
  logic        cmd_error;
  logic        overrun;

  typedef struct {
    logic [7:0] b;
    bit         second;
  } tx_exp_t;

  tx_exp_t     exp_tx[$];
  logic [11:0] exp_wr[$];
  logic [3:0]  exp_fun[$];
  logic [7:0]  mem[16];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int trig_cyc = 0;
  int fall_cyc = 0;
  int alu_lat = 1;
  int alu_cnt = 0;
  logic [15:0] alu_val = '0;

  sys_ctrl dut (
    .CLK           (CLK),
    .RST           (RST),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rf_addr       (rf_addr),
    .rf_wr_en      (rf_wr_en),
    .rf_wr_data    (rf_wr_data),
    .rf_rd_en      (rf_rd_en),
    .rf_rd_data    (rf_rd_data),
    .rf_rd_valid   (rf_rd_valid),
    .alu_fun       (alu_fun),
    .alu_en        (alu_en),
    .alu_out       (alu_out),
    .alu_out_valid (alu_out_valid),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_busy       (tx_busy),
    .cmd_error     (cmd_error),
    .overrun       (overrun)
  );

  initial forever #5 CLK = ~CLK;
  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Register file: read data valid exactly one cycle after rf_rd_en; writes checked against the scoreboard.
  initial begin
    logic       pend;
    logic [7:0] pdata;
    pend = 1'b0;
    pdata = '0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h50 + 8'(i);
    forever begin
      @(posedge CLK); #1;
      rf_rd_valid = pend;
      if (pend) begin
        rf_rd_data = pdata;
        trig_cyc = cyc;
      end
      pend = rf_rd_en;
      pdata = mem[rf_addr];
      if (rf_wr_en) begin
        chk("rf_wr_expected", 32'(exp_wr.size() != 0), 1);
        if (exp_wr.size() != 0) begin
          logic [11:0] e;
          e = exp_wr.pop_front();
          chk("rf_wr_addr", 32'(rf_addr), 32'(e[11:8]));
          chk("rf_wr_data", 32'(rf_wr_data), 32'(e[7:0]));
        end
        mem[rf_addr] = rf_wr_data;
      end
    end
  end

  // ALU: result strobe alu_lat cycles after alu_en.
  initial forever begin
    @(posedge CLK); #1;
    alu_out_valid = 1'b0;
    if (alu_cnt > 0) begin
      alu_cnt--;
      if (alu_cnt == 0) begin
        alu_out_valid = 1'b1;
        alu_out = alu_val;
        trig_cyc = cyc;
      end
    end
    if (alu_en) begin
      chk("alu_en_expected", 32'(exp_fun.size() != 0), 1);
      if (exp_fun.size() != 0) chk("alu_fun", 32'(alu_fun), 32'(exp_fun.pop_front()));
      alu_cnt = alu_lat;
    end
  end

  // UART_TX: Busy for 5 cycles per accepted frame; bytes popped from the scoreboard.
  initial begin
    int   busy_cnt;
    logic prev_v;
    busy_cnt = 0;
    prev_v = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          tx_busy = 1'b0;
          fall_cyc = cyc;
        end
      end
      if (tx_data_valid) begin
        chk("tx_valid_width", 32'(prev_v), 0);
        chk("tx_expected", 32'(exp_tx.size() != 0), 1);
        if (exp_tx.size() != 0) begin
          tx_exp_t e;
          e = exp_tx.pop_front();
          chk("tx_byte", 32'(tx_data), 32'(e.b));
          if (e.second) chk("tx_second_latency", 32'(cyc - fall_cyc), 1);
          else          chk("tx_first_latency", 32'(cyc - trig_cyc), 2);
        end
        if (!prev_v) begin
          tx_busy = 1'b1;
          busy_cnt = 5;
        end
      end
      prev_v = tx_data_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_frame(input logic [7:0] b);
    @(posedge CLK); #1;
    rx_data = b;
    rx_data_valid = 1'b1;
    @(posedge CLK); #1;
    rx_data_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (exp_tx.size() == 0 && !tx_busy) break;
      @(posedge CLK);
    end
    repeat (3) @(posedge CLK);
    #1;
    chk("drain_tx", 32'(exp_tx.size()), 0);
    chk("drain_wr", 32'(exp_wr.size()), 0);
    chk("drain_fun", 32'(exp_fun.size()), 0);
  endtask

  task automatic wait_busy_fall();
    int n;
    n = 0;
    while (!tx_busy && n < 200) begin @(posedge CLK); #2; n++; end
    while (tx_busy && n < 400) begin @(posedge CLK); #2; n++; end
    chk("busy_fall_seen", 32'(tx_busy), 0);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outputs", 32'({rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, alu_fun, alu_en,
                              tx_data, tx_data_valid, cmd_error, overrun}), 0);
    RST = 1'b1;

    // Write AA 05 3C
    exp_wr.push_back({4'h5, 8'h3C});
    send_frame(8'hAA);
    send_frame(8'h05);
    send_frame(8'h3C);
    chk("wr_strobe", 32'(rf_wr_en), 1);
    chk("wr_addr", 32'(rf_addr), 5);
    chk("wr_data", 32'(rf_wr_data), 'h3C);
    @(posedge CLK); #1;
    chk("wr_strobe_width", 32'(rf_wr_en), 0);
    drain();

    // Read BB 05
    exp_tx.push_back('{8'h3C, 1'b0});
    send_frame(8'hBB);
    send_frame(8'h05);
    chk("rd_strobe", 32'(rf_rd_en), 1);
    chk("rd_addr", 32'(rf_addr), 5);
    drain();

    // ALU with operands CC 12 34 01
    exp_wr.push_back({4'h0, 8'h12});
    exp_wr.push_back({4'h1, 8'h34});
    exp_fun.push_back(4'h1);
    alu_val = 16'h0046;
    alu_lat = 3;
    exp_tx.push_back('{8'h46, 1'b0});
    exp_tx.push_back('{8'h00, 1'b1});
    send_frame(8'hCC);
    send_frame(8'h12);
    send_frame(8'h34);
    send_frame(8'h01);
    chk("alu_en", 32'(alu_en), 1);
    chk("alu_fun_at_strobe", 32'(alu_fun), 1);
    drain();

    // ALU without operands DD 0F
    exp_fun.push_back(4'hF);
    alu_val = 16'hA3FF;
    alu_lat = 6;
    exp_tx.push_back('{8'hFF, 1'b0});
    exp_tx.push_back('{8'hA3, 1'b1});
    send_frame(8'hDD);
    send_frame(8'h0F);
    drain();

    // Unknown opcode
    send_frame(8'h7E);
    chk("cmd_error", 32'(cmd_error), 1);
    chk("cmd_error_no_overrun", 32'(overrun), 0);
    @(posedge CLK); #1;
    chk("cmd_error_width", 32'(cmd_error), 0);

    // Read BB 02, with a frame coincident with the response completing
    exp_tx.push_back('{8'h52, 1'b0});
    send_frame(8'hBB);
    send_frame(8'h02);
    wait_busy_fall();
    rx_data = 8'h7E;
    rx_data_valid = 1'b1;
    @(posedge CLK); #1;
    rx_data_valid = 1'b0;
    chk("overrun_at_done", 32'(overrun), 1);
    chk("no_cmd_error_at_done", 32'(cmd_error), 0);
    drain();

    // Frame injected during RESP
    exp_tx.push_back('{8'h3C, 1'b0});
    send_frame(8'hBB);
    send_frame(8'h05);
    for (int i = 0; i < 100 && !tx_busy; i++) @(posedge CLK);
    send_frame(8'hBB);
    chk("overrun_resp", 32'(overrun), 1);
    @(posedge CLK); #1;
    chk("overrun_width", 32'(overrun), 0);
    drain();

    // Frame injected during ALU_WAIT
    exp_fun.push_back(4'h3);
    alu_val = 16'h1234;
    alu_lat = 12;
    exp_tx.push_back('{8'h34, 1'b0});
    exp_tx.push_back('{8'h12, 1'b1});
    send_frame(8'hDD);
    send_frame(8'h03);
    send_frame(8'hAA);
    chk("overrun_alu_wait", 32'(overrun), 1);
    drain();

    // Reset during WR_DATA abandons the write
    send_frame(8'hAA);
    send_frame(8'h05);
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    chk("midcmd_reset_outputs", 32'({rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, alu_fun, alu_en,
                                     tx_data, tx_data_valid, cmd_error, overrun}), 0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    send_frame(8'h3C);
    chk("post_reset_cmd_error", 32'(cmd_error), 1);
    chk("post_reset_no_write", 32'(rf_wr_en), 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sys_ctrl.md
# sys_ctrl

Command sequencer between the UART receive path and the register file / ALU, returning results through the UART transmit path. It parses byte-serial command frames from `UART_RX`, performs register-file writes and reads and ALU operations, and streams 1- or 2-byte responses into `UART_TX` under its `Busy` handshake. It runs on the system clock domain; RX frames arrive already synchronized.

## Interface
Parameters:
- `DATA_WIDTH`, 8 — frame, register-file and operand width (`dataframe_t`).
- `ADDR_WIDTH`, 4 — register-file address width.
- `ALU_WIDTH`, 16 — ALU result width; always sent as two frames.

Ports:
- `CLK`  in  1  system clock.
- `RST`  in  1  reset, asynchronous, active-low.
- `rx_data`  in  `DATA_WIDTH`  received frame.
- `rx_data_valid`  in  1  one-cycle strobe qualifying `rx_data`.
- `rf_addr`  out  `ADDR_WIDTH`  register-file address.
- `rf_wr_en`  out  1  one-cycle write strobe.
- `rf_wr_data`  out  `DATA_WIDTH`  write data.
- `rf_rd_en`  out  1  one-cycle read strobe.
- `rf_rd_data`  in  `DATA_WIDTH`  read data.
- `rf_rd_valid`  in  1  read data valid, exactly 1 cycle after `rf_rd_en`.
- `alu_fun`  out  4  ALU function code.
- `alu_en`  out  1  one-cycle ALU start strobe; operands are register-file addresses 0 (A) and 1 (B).
- `alu_out`  in  `ALU_WIDTH`  ALU result.
- `alu_out_valid`  in  1  result strobe, arrives any number of cycles after `alu_en`.
- `tx_data`  out  `DATA_WIDTH`  frame to `UART_TX` `P_DATA`.
- `tx_data_valid`  out  1  one-cycle load strobe to `UART_TX` `DATA_VALID`.
- `tx_busy`  in  1  `UART_TX` `Busy`.
- `cmd_error`  out  1  one-cycle pulse when an opcode is unknown.
- `overrun`  out  1  one-cycle pulse when a frame arrives while the block cannot accept it.

## Operation
Opcodes (first frame of a command):
- `0xAA` = write: addr, data.
- `0xBB` = read: addr → 1-byte response.
- `0xCC` = ALU with operands: A, B, fun → 2-byte response.
- `0xDD` = ALU without operands: fun → 2-byte response.

Only the low `ADDR_WIDTH` bits of an addr frame are used. Only the low 4 bits of a fun frame are used.

Main FSM states: `IDLE`, `WR_ADDR`, `WR_DATA`, `RD_ADDR`, `RD_WAIT`, `OP_A`, `OP_B`, `ALU_FUN`, `ALU_WAIT`, `RESP`.
- `IDLE`:
  - Known opcode → next state per command (`OP_A` for `0xCC`, `ALU_FUN` for `0xDD`).
  - Unknown opcode → `cmd_error` pulse; stay in `IDLE`.
- `WR_DATA` on a frame: `rf_wr_en`, then → `IDLE`.
- `OP_A` on a frame: writes address 0.
- `OP_B` on a frame: writes address 1.
- `ALU_FUN` on a frame: `alu_en` + `alu_fun` → `ALU_WAIT`.
- `RD_ADDR` on a frame: `rf_rd_en` → `RD_WAIT`.
- `RD_WAIT` captures `rf_rd_data` on `rf_rd_valid`. `ALU_WAIT` captures `alu_out` on `alu_out_valid`.
- After capture: load the response buffer (1 or 2 bytes, low byte first) → `RESP`. Stay in `RESP` until the sequencer reports done → `IDLE`.
- A frame with `rx_data_valid` in `RD_WAIT`, `ALU_WAIT` or `RESP` is dropped with an `overrun` pulse.

TX sequencer states: `T_IDLE`, `T_LOAD`, `T_WAIT_HI`, `T_WAIT_LO`.
- `T_LOAD` drives `tx_data_valid` for exactly one cycle, only when `tx_busy`=0.
- `T_WAIT_HI` waits for `tx_busy`=1.
- `T_WAIT_LO` waits for `tx_busy`=0, then loads the next byte or reports done.

## Timing
- Reset: all outputs 0, `rf_addr`=0, FSMs in `IDLE`/`T_IDLE`, buffer cleared. Reset mid-command abandons the command; no partial write is issued afterwards.
- Strobe outputs (`rf_wr_en`, `rf_rd_en`, `alu_en`, `tx_data_valid`, `cmd_error`, `overrun`) are registered and assert the cycle after the triggering `rx_data_valid`/event, for 1 cycle.
- `rf_addr`, `rf_wr_data`, `alu_fun` and `tx_data` are stable while their strobe is high.
- Read response: first `tx_data_valid` is 2 cycles after `rf_rd_valid`. ALU response: same, counted from `alu_out_valid`.
- Second ALU byte: `tx_data_valid` is 1 cycle after `tx_busy` falls.
- `rx_data_valid` coincident with the last response byte completing (`RESP` → `IDLE`) is treated as `overrun`. The block does not return to `IDLE` until the cycle after done.

## Structure
- `SYS_PKG` holds `dataframe_t`, the opcode constants (`CMD_WR`, `CMD_RD`, `CMD_ALU_OP`, `CMD_ALU_NOP`) and the main-FSM state enum.
- Sub-module `sys_ctrl_tx_seq` holds the 2-entry response buffer and the `Busy` handshake FSM. Its interface:
  - `load`, `len`, `byte0`, `byte1` in.
  - `done` out, plus the TX ports.

## Test plan
- Frames `AA 05 3C` → `rf_wr_en` pulse with `rf_addr`=5, `rf_wr_data`=`0x3C`. No TX activity.
- Frames `BB 05`, model returns `0x3C` → `rf_rd_en` with addr 5, then one TX frame `0x3C`. `tx_data_valid` is high for exactly 1 cycle.
- Frames `CC 12 34 01`, model `alu_out`=`0x0046` after 3 cycles → writes addr0=`0x12`, addr1=`0x34`; `alu_en` with fun 1; TX `0x46` then `0x00`. The second load comes only after `tx_busy` falls.
- Frames `DD 0F`, ALU returns `0xA3FF` → TX `0xFF`, `0xA3`.
- Frame `7E` → `cmd_error` pulse, FSM stays in `IDLE`. A subsequent `BB 02` is processed normally.
- Frame injected during `RESP` → `overrun` pulse and the response bytes are unaltered. `RST`=0 during `WR_DATA` → all outputs 0 and no `rf_wr_en` after release.
